// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain programming front-end: accepts bitstream words over valid/ready
// and shifts exactly CHAIN_LEN bits, LSB first, into the fabric configuration chain.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic              err_overrun
);

  localparam int NW       = (CHAIN_LEN + DATA_W - 1) / DATA_W;
  localparam int REM      = CHAIN_LEN % DATA_W;
  localparam int LAST_LEN = (REM == 0) ? DATA_W : REM;
  localparam int WA_W     = $clog2(NW + 1);
  localparam int LEN_W    = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] BITS_ALL  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WA_W-1:0]  WORDS_ALL = WA_W'(NW);
  localparam logic [WA_W-1:0]  WORD_LAST = WA_W'(NW - 1);
  localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] LEN_TAIL  = LEN_W'(LAST_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] hb;
  logic [LEN_W-1:0]  sr_cnt;
  logic [LEN_W-1:0]  hb_len;
  logic              hb_full;
  logic [WA_W-1:0]   words;
  logic              accept;
  logic [LEN_W-1:0]  in_len;

  always_comb begin
    in_ready = (state == S_RUN) && !hb_full && (words < WORDS_ALL);
    accept   = in_valid && in_ready;
    // The final word of a non-multiple chain only contributes its low bits.
    in_len   = (words == WORD_LAST) ? LEN_TAIL : LEN_FULL;
    busy     = (state == S_RUN);
    done     = (state == S_DONE);
  end

  // ccff_head/ccff_shift_en describe the bit being shifted in the current cycle;
  // sr holds only the bits of the current word not yet presented.
  always_ff @(posedge CK) begin
    if (!RN) begin
      state         <= S_IDLE;
      sr            <= '0;
      hb            <= '0;
      sr_cnt        <= '0;
      hb_len        <= '0;
      hb_full       <= 1'b0;
      words         <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      bit_count     <= '0;
      err_overrun   <= 1'b0;
    end else if (abort) begin
      state         <= S_IDLE;
      sr            <= '0;
      hb            <= '0;
      sr_cnt        <= '0;
      hb_len        <= '0;
      hb_full       <= 1'b0;
      words         <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      bit_count     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_RUN;
            sr_cnt        <= '0;
            hb_full       <= 1'b0;
            words         <= '0;
            bit_count     <= '0;
            ccff_shift_en <= 1'b0;
            err_overrun   <= 1'b0;
          end
        end
        S_RUN: begin
          if (ccff_shift_en && (bit_count != BITS_ALL))
            bit_count <= bit_count + CNT_W'(1);
          if (accept)
            words <= words + WA_W'(1);
          if (ccff_shift_en && (bit_count == BITS_LAST)) begin
            state         <= S_DONE;
            ccff_shift_en <= 1'b0;
          end else if (sr_cnt != '0) begin
            ccff_head     <= sr[0];
            sr            <= sr >> 1;
            sr_cnt        <= sr_cnt - LEN_ONE;
            ccff_shift_en <= 1'b1;
            if (accept) begin
              hb      <= in_data;
              hb_len  <= in_len;
              hb_full <= 1'b1;
            end
          end else if (hb_full) begin
            ccff_head     <= hb[0];
            sr            <= hb >> 1;
            sr_cnt        <= hb_len - LEN_ONE;
            hb_full       <= 1'b0;
            ccff_shift_en <= 1'b1;
          end else if (accept) begin
            ccff_head     <= in_data[0];
            sr            <= in_data >> 1;
            sr_cnt        <= in_len - LEN_ONE;
            ccff_shift_en <= 1'b1;
          end else begin
            ccff_shift_en <= 1'b0;
          end
        end
        S_DONE: begin
          if (start) begin
            state         <= S_RUN;
            sr_cnt        <= '0;
            hb_full       <= 1'b0;
            words         <= '0;
            bit_count     <= '0;
            ccff_shift_en <= 1'b0;
            err_overrun   <= 1'b0;
          end else if (in_valid) begin
            err_overrun <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench: expected serial bits are queued when words are issued and a
// negedge monitor pops one per shift_en pulse; status is checked directly.
module tb_ccff_bitstream_loader;

  localparam int A_LEN = 64;
  localparam int A_W   = 8;
  localparam int A_CW  = $clog2(A_LEN + 1);
  localparam int B_LEN = 20;
  localparam int B_W   = 8;
  localparam int B_CW  = $clog2(B_LEN + 1);

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic            a_rn, a_start, a_abort, a_valid, a_ready, a_head, a_shift, a_busy, a_done, a_err;
  logic [A_W-1:0]  a_data;
  logic [A_CW-1:0] a_bc;
  logic            b_rn, b_start, b_abort, b_valid, b_ready, b_head, b_shift, b_busy, b_done, b_err;
  logic [B_W-1:0]  b_data;
  logic [B_CW-1:0] b_bc;

  ccff_bitstream_loader #(.CHAIN_LEN(A_LEN), .DATA_W(A_W)) dut_a (
    .CK(CK), .RN(a_rn), .start(a_start), .abort(a_abort),
    .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .ccff_head(a_head), .ccff_shift_en(a_shift), .busy(a_busy), .done(a_done),
    .bit_count(a_bc), .err_overrun(a_err)
  );

  ccff_bitstream_loader #(.CHAIN_LEN(B_LEN), .DATA_W(B_W)) dut_b (
    .CK(CK), .RN(b_rn), .start(b_start), .abort(b_abort),
    .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .ccff_head(b_head), .ccff_shift_en(b_shift), .busy(b_busy), .done(b_done),
    .bit_count(b_bc), .err_overrun(b_err)
  );

  int tests = 0;
  int fails = 0;
  bit a_q[$];
  bit b_q[$];
  int a_pulses = 0, a_run = 0, a_max_run = 0, b_pulses = 0;
  int trig_kind = 0, trig_at = 0;
  bit trig_done = 1'b0, pulse_active = 1'b0, killed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  always @(negedge CK) begin
    if (a_shift === 1'b1) begin
      a_pulses++;
      a_run++;
      if (a_run > a_max_run) a_max_run = a_run;
      if (a_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_extra_shift: shift_en with nothing expected, head=%0b", a_head);
      end else chk("a_serial_bit", 32'(a_head), 32'(a_q.pop_front()));
    end else a_run = 0;
  end

  always @(negedge CK) begin
    if (b_shift === 1'b1) begin
      b_pulses++;
      if (b_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_extra_shift: shift_en with nothing expected, head=%0b", b_head);
      end else chk("b_serial_bit", 32'(b_head), 32'(b_q.pop_front()));
    end
  end

  task automatic a_push(input logic [A_W-1:0] w);
    for (int unsigned i = 0; i < A_W; i++) a_q.push_back(w[i]);
  endtask

  task automatic b_push(input logic [B_W-1:0] w, input int idx);
    int len;
    len = (idx == (B_LEN + B_W - 1) / B_W - 1 && (B_LEN % B_W) != 0) ? (B_LEN % B_W) : B_W;
    for (int i = 0; i < len; i++) b_q.push_back(w[i]);
  endtask

  // One clock for DUT A; ends any one-cycle pulse and fires the armed trigger.
  task automatic a_cycle();
    @(posedge CK);
    #1;
    if (pulse_active) begin
      a_start = 1'b0;
      a_abort = 1'b0;
      a_rn = 1'b1;
      pulse_active = 1'b0;
    end
    if (trig_kind != 0 && !trig_done && int'(a_bc) == trig_at) begin
      trig_done = 1'b1;
      pulse_active = 1'b1;
      case (trig_kind)
        1: a_start = 1'b1;
        2: begin a_rn = 1'b0; killed = 1'b1; a_valid = 1'b0; end
        default: begin a_abort = 1'b1; killed = 1'b1; a_valid = 1'b0; end
      endcase
    end
  endtask

  task automatic b_cycle();
    @(posedge CK);
    #1;
  endtask

  task automatic a_send(input int lo, input int hi, input bit check_first, input int exp_bc);
    int n;
    for (int i = lo; i <= hi && !killed; i++) begin
      logic [A_W-1:0] w;
      w = A_W'(i + 1);
      a_valid = 1'b1;
      a_data = w;
      a_push(w);
      n = 0;
      while (!a_ready && !killed && n < 100) begin a_cycle(); n++; end
      if (killed) break;
      if (n >= 100) begin fail_now("a_ready_wait"); break; end
      a_cycle();
      if (check_first && i == lo) begin
        chk("a_first_shift_latency", 32'(a_shift), 32'd1);
        chk("a_first_head", 32'(a_head), 32'(w[0]));
        chk("a_first_bit_count", 32'(a_bc), 32'(exp_bc));
      end
    end
    if (!killed) a_valid = 1'b0;
  endtask

  task automatic a_wait_done();
    logic prev;
    int n;
    n = 0;
    prev = a_shift;
    while (!a_done && n < 300) begin prev = a_shift; a_cycle(); n++; end
    if (!a_done) fail_now("a_done_wait");
    else chk("a_done_after_last_shift", 32'(prev), 32'd1);
  endtask

  task automatic a_clear_mon();
    a_pulses = 0;
    a_run = 0;
    a_max_run = 0;
  endtask

  task automatic a_check_zero(input string tag);
    chk({tag, "_busy"}, 32'(a_busy), 32'd0);
    chk({tag, "_done"}, 32'(a_done), 32'd0);
    chk({tag, "_shift_en"}, 32'(a_shift), 32'd0);
    chk({tag, "_head"}, 32'(a_head), 32'd0);
    chk({tag, "_bit_count"}, 32'(a_bc), 32'd0);
    chk({tag, "_in_ready"}, 32'(a_ready), 32'd0);
    chk({tag, "_err"}, 32'(a_err), 32'd0);
  endtask

  task automatic a_pulse_start();
    a_start = 1'b1;
    a_cycle();
    a_start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, viol;
    a_rn = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_valid = 1'b0; a_data = '0;
    b_rn = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_valid = 1'b0; b_data = '0;
    a_cycle();
    a_cycle();
    a_check_zero("reset");
    a_rn = 1'b1;
    b_rn = 1'b1;

    // Continuous 64-bit load of 0x01..0x08.
    a_clear_mon();
    a_pulse_start();
    chk("start_busy", 32'(a_busy), 32'd1);
    chk("start_in_ready", 32'(a_ready), 32'd1);
    a_send(0, 7, 1'b1, 0);
    a_wait_done();
    chk("cont_pulses", 32'(a_pulses), 32'd64);
    chk("cont_max_run", 32'(a_max_run), 32'd64);
    chk("cont_bit_count", 32'(a_bc), 32'd64);
    chk("done_in_ready", 32'(a_ready), 32'd0);

    // Overrun in DONE, then restart clears it.
    a_valid = 1'b1;
    a_data = 8'hAA;
    chk("overrun_in_ready", 32'(a_ready), 32'd0);
    a_cycle();
    a_valid = 1'b0;
    chk("overrun_err", 32'(a_err), 32'd1);
    chk("overrun_done", 32'(a_done), 32'd1);
    chk("overrun_no_shift", 32'(a_shift), 32'd0);
    chk("overrun_pulses", 32'(a_pulses), 32'd64);
    a_pulse_start();
    chk("restart_err", 32'(a_err), 32'd0);
    chk("restart_busy", 32'(a_busy), 32'd1);
    chk("restart_bit_count", 32'(a_bc), 32'd0);
    chk("restart_done", 32'(a_done), 32'd0);

    // Stall after word 3, then bubble-free resume.
    a_clear_mon();
    a_send(0, 2, 1'b1, 0);
    n = 0;
    while (a_shift && n < 50) begin a_cycle(); n++; end
    chk("stall_bit_count", 32'(a_bc), 32'd24);
    for (int i = 0; i < 5; i++) begin
      a_cycle();
      chk("stall_shift_en", 32'(a_shift), 32'd0);
      chk("stall_hold_count", 32'(a_bc), 32'd24);
      chk("stall_head_hold", 32'(a_head), 32'd0);
    end
    a_send(3, 7, 1'b1, 24);
    a_wait_done();
    chk("stall_pulses", 32'(a_pulses), 32'd64);
    chk("stall_resume_run", 32'(a_max_run), 32'd40);

    // start during RUN is ignored.
    a_clear_mon();
    a_pulse_start();
    killed = 1'b0; trig_done = 1'b0; trig_at = 10; trig_kind = 1;
    a_send(0, 7, 1'b0, 0);
    a_wait_done();
    trig_kind = 0;
    chk("run_start_fired", 32'(trig_done), 32'd1);
    chk("run_start_pulses", 32'(a_pulses), 32'd64);
    chk("run_start_count", 32'(a_bc), 32'd64);

    // Reset mid-load at bit_count 30.
    a_pulse_start();
    killed = 1'b0; trig_done = 1'b0; trig_at = 30; trig_kind = 2;
    a_send(0, 7, 1'b0, 0);
    trig_kind = 0;
    if (!killed) fail_now("reset_trigger");
    a_cycle();
    a_check_zero("midreset");
    a_q.delete();
    a_cycle();
    chk("midreset_no_shift", 32'(a_shift), 32'd0);

    // Abort mid-load at bit_count 30.
    a_pulse_start();
    killed = 1'b0; trig_done = 1'b0; trig_at = 30; trig_kind = 3;
    a_send(0, 7, 1'b0, 0);
    trig_kind = 0;
    if (!killed) fail_now("abort_trigger");
    a_cycle();
    a_check_zero("abort");
    a_q.delete();
    a_cycle();
    chk("abort_no_shift", 32'(a_shift), 32'd0);
    killed = 1'b0;

    // 20-bit chain with 8-bit words: last word contributes 4 bits.
    b_start = 1'b1;
    b_cycle();
    b_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1;
      b_data = 8'hFF;
      b_push(8'hFF, i);
      n = 0;
      while (!b_ready && n < 100) begin b_cycle(); n++; end
      if (n >= 100) fail_now("b_ready_wait");
      b_cycle();
    end
    b_data = 8'h00;
    chk("b_ready_after_last", 32'(b_ready), 32'd0);
    n = 0;
    viol = 0;
    while (!b_done && n < 100) begin
      b_cycle();
      if (b_ready) viol++;
      n++;
    end
    b_valid = 1'b0;
    chk("b_ready_stays_low", 32'(viol), 32'd0);
    chk("b_done", 32'(b_done), 32'd1);
    chk("b_pulses", 32'(b_pulses), 32'd20);
    chk("b_bit_count", 32'(b_bc), 32'd20);
    chk("b_err", 32'(b_err), 32'd0);

    b_cycle();
    chk("a_queue_drained", 32'(a_q.size()), 32'd0);
    chk("b_queue_drained", 32'(b_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
